// File: rtl/intc_pkg.sv
// Shared definitions for the intc_vec vectored interrupt controller:
// register map, FSM state type and index-width helper.
package intc_pkg;

    localparam logic [1:0] INTC_MASK   = 2'd0;
    localparam logic [1:0] INTC_MODE   = 2'd1;
    localparam logic [1:0] INTC_PEND   = 2'd2;
    localparam logic [1:0] INTC_INSERV = 2'd3;

    typedef enum logic {
        IDLE,
        REQ
    } intc_state_e;

    // Width needed to hold a channel index; never zero so N=1 still yields a legal vector.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder: idx is the lowest set bit of req, valid when any is set.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/intc_vec.sv
// Vectored interrupt controller: mask/mode/pending/in-service tracking, fixed-priority
// arbitration and INTin/INTnum handshake. Define INTC_NEST_EN to allow strict preemption.
module intc_vec
    import intc_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned VEC_BASE = 0,
    parameter int unsigned VEC_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  irq,
    output logic             INTin,
    output logic [VEC_W-1:0] INTnum,
    input  logic             int_ack,
    input  logic             int_eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata
);

    localparam int unsigned IW = idx_w(N_CH);

    logic [N_CH-1:0]  mask_q, mask_d;
    logic [N_CH-1:0]  mode_q, mode_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  inserv_q, inserv_d;
    logic [N_CH-1:0]  irq_d;
    intc_state_e      state_q, state_d;
    logic [IW-1:0]    chan_q, chan_d;
    logic [VEC_W-1:0] intnum_q, intnum_d;

    logic [N_CH-1:0]  wdata;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  w1c_bits;
    logic [N_CH-1:0]  ack_bits;
    logic [N_CH-1:0]  eoi_bits;
    logic             win_valid;
    logic [IW-1:0]    win_idx;
    logic             ins_valid;
    logic [IW-1:0]    ins_idx;
    logic             allow;
    logic             ack;
    logic             unused_wdata;

    assign wdata        = cfg_wdata[N_CH-1:0];
    assign unused_wdata = ^cfg_wdata;

    // Edge channels keep a sticky bit; level channels just follow the registered line.
    assign pend     = (pend_q & mode_q) | (irq_d & ~mode_q);
    assign eligible = pend & mask_q & ~inserv_q;
    assign rise     = irq & ~irq_d;

    intc_prio_enc #(
        .N (N_CH)
    ) u_win (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    intc_prio_enc #(
        .N (N_CH)
    ) u_ins (
        .req   (inserv_q),
        .valid (ins_valid),
        .idx   (ins_idx)
    );

`ifdef INTC_NEST_EN
    assign allow = win_valid && (!ins_valid || (win_idx < ins_idx));
`else
    assign allow = win_valid && !ins_valid;
`endif

    assign ack      = (state_q == REQ) && int_ack;
    assign ack_bits = ack ? (N_CH'(1) << chan_q) : '0;
    assign eoi_bits = (int_eoi && ins_valid) ? (N_CH'(1) << ins_idx) : '0;
    assign w1c_bits = (cfg_we && (cfg_addr == INTC_PEND)) ? wdata : '0;

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (cfg_we && (cfg_addr == INTC_MASK)) begin
            mask_d = wdata;
        end
        if (cfg_we && (cfg_addr == INTC_MODE)) begin
            mode_d = wdata;
        end
        // A new edge overrides both W1C and ack clears in the same cycle.
        pend_d   = ((pend_q & ~w1c_bits & ~ack_bits) | rise) & mode_q;
        // EOI retires the old lowest bit before ack adds the new one.
        inserv_d = (inserv_q & ~eoi_bits) | ack_bits;
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        intnum_d = intnum_q;
        unique case (state_q)
            IDLE: begin
                if (allow) begin
                    state_d  = REQ;
                    chan_d   = win_idx;
                    intnum_d = VEC_W'(VEC_BASE) + VEC_W'(win_idx);
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q   <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            inserv_q <= '0;
            irq_d    <= '0;
            state_q  <= IDLE;
            chan_q   <= '0;
            intnum_q <= '0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            inserv_q <= inserv_d;
            irq_d    <= irq;
            state_q  <= state_d;
            chan_q   <= chan_d;
            intnum_q <= intnum_d;
        end
    end

    assign INTin  = (state_q == REQ);
    assign INTnum = intnum_q;

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            INTC_MASK:   cfg_rdata[N_CH-1:0] = mask_q;
            INTC_MODE:   cfg_rdata[N_CH-1:0] = mode_q;
            INTC_PEND:   cfg_rdata[N_CH-1:0] = pend;
            INTC_INSERV: cfg_rdata[N_CH-1:0] = inserv_q;
            default:     cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intc_vec.sv
// Testbench for intc_vec: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural model. Honours INTC_NEST_EN like the design.
module tb_intc_vec;

    localparam int N  = 8;
    localparam int VB = 16;
    localparam int VW = 32;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [N-1:0]  irq       = '0;
    logic          int_ack   = 1'b0;
    logic          int_eoi   = 1'b0;
    logic          cfg_we    = 1'b0;
    logic [1:0]    cfg_addr  = 2'd0;
    logic [31:0]   cfg_wdata = '0;
    logic          INTin;
    logic [VW-1:0] INTnum;
    logic [31:0]   cfg_rdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    intc_vec #(
        .N_CH     (N),
        .VEC_BASE (VB),
        .VEC_W    (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .INTin     (INTin),
        .INTnum    (INTnum),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: per-channel bookkeeping straight from the register rules.
    logic [N-1:0] m_mask, m_mode, m_pend_e, m_inserv, m_irq_d;
    bit           m_req;
    int           m_chan;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_pend();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_pend_e[i] : m_irq_d[i];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_mode);
            2'd2:    return 32'(m_pend());
            default: return 32'(m_inserv);
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mask <= '0; m_mode <= '0; m_pend_e <= '0; m_inserv <= '0; m_irq_d <= '0;
            m_req  <= 1'b0;
            m_chan <= 0;
        end else begin : upd
            logic [N-1:0] nx_pend, nx_ins;
            int  w, lo;
            bit  ack, ok;
            w   = lowest(m_pend() & m_mask & ~m_inserv);
            lo  = lowest(m_inserv);
            ack = m_req && int_ack;
            nx_ins = m_inserv;
            if (int_eoi && lo >= 0) nx_ins[lo] = 1'b0;
            if (ack) nx_ins[m_chan] = 1'b1;
            for (int i = 0; i < N; i++) begin
                nx_pend[i] = 1'b0;
                if (m_mode[i]) begin
                    nx_pend[i] = m_pend_e[i];
                    if (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) nx_pend[i] = 1'b0;
                    if (ack && m_chan == i) nx_pend[i] = 1'b0;
                    if (irq[i] && !m_irq_d[i]) nx_pend[i] = 1'b1;
                end
            end
`ifdef INTC_NEST_EN
            ok = (w >= 0) && (lo < 0 || w < lo);
`else
            ok = (w >= 0) && (lo < 0);
`endif
            if (m_req) begin
                if (int_ack) m_req <= 1'b0;
            end else if (ok) begin
                m_req  <= 1'b1;
                m_chan <= w;
            end
            if (cfg_we && cfg_addr == 2'd0) m_mask <= cfg_wdata[N-1:0];
            if (cfg_we && cfg_addr == 2'd1) m_mode <= cfg_wdata[N-1:0];
            m_pend_e <= nx_pend;
            m_inserv <= nx_ins;
            m_irq_d  <= irq;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_intin", 32'(INTin), 32'(m_req));
            if (m_req) chk("cyc_intnum", INTnum, 32'(VB + m_chan));
            chk("cyc_rdata", cfg_rdata, m_read(cfg_addr));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(nm, cfg_rdata, exp);
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_intin", 32'(INTin), 32'd0);
        chk("rst_intnum", INTnum, 32'd0);
        rd_chk("rst_mask", 2'd0, 32'h0);
        rd_chk("rst_inserv", 2'd3, 32'h0);
        #8 rst = 1'b1;
        tick(2);

        // Edge request on channel 0
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h01);
        irq[0] = 1'b1;
        tick();
        rd_chk("edge_pend_n1", 2'd2, 32'h01);
        chk("edge_intin_n1", 32'(INTin), 32'd0);
        irq[0] = 1'b0;
        tick();
        chk("edge_intin_n2", 32'(INTin), 32'd1);
        chk("edge_intnum", INTnum, 32'(VB));
        tick(2);
        chk("edge_hold", 32'(INTin), 32'd1);
        do_ack();
        chk("edge_ack_intin", 32'(INTin), 32'd0);
        rd_chk("edge_ack_inserv", 2'd3, 32'h01);
        rd_chk("edge_ack_pend", 2'd2, 32'h00);
        do_eoi();
        rd_chk("edge_eoi_inserv", 2'd3, 32'h00);
        tick();

        // Fixed priority: 2 beats 5
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        irq = 8'h24;
        tick();
        irq = '0;
        tick();
        chk("prio_first", INTnum, 32'(VB + 2));
        do_ack();
        rd_chk("prio_inserv", 2'd3, 32'h04);
        tick(2);
        chk("prio_blocked", 32'(INTin), 32'd0);
        do_eoi();
        chk("prio_eoi_e1", 32'(INTin), 32'd0);
        tick();
        chk("prio_second_in", 32'(INTin), 32'd1);
        chk("prio_second", INTnum, 32'(VB + 5));
        do_ack();
        do_eoi();
        tick();

        // Masking and W1C
        wr(2'd0, 32'h00);
        wr(2'd1, 32'h08);
        irq[3] = 1'b1;
        tick(2);
        rd_chk("mask_pend", 2'd2, 32'h08);
        chk("mask_intin", 32'(INTin), 32'd0);
        wr(2'd2, 32'h08);
        rd_chk("w1c_pend", 2'd2, 32'h00);
        irq[3] = 1'b0;
        tick();
        irq[3] = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h08;
        tick();
        cfg_we = 1'b0;
        rd_chk("w1c_collide", 2'd2, 32'h08);
        irq = '0;
        wr(2'd2, 32'hFF);
        rd_chk("w1c_clean", 2'd2, 32'h00);

        // Level mode on channel 1
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h02);
        irq[1] = 1'b1;
        tick(2);
        chk("lvl_intin", 32'(INTin), 32'd1);
        chk("lvl_intnum", INTnum, 32'(VB + 1));
        do_ack();
        rd_chk("lvl_inserv", 2'd3, 32'h02);
        rd_chk("lvl_pend_kept", 2'd2, 32'h02);
        do_eoi();
        chk("lvl_eoi_e1", 32'(INTin), 32'd0);
        tick();
        chk("lvl_rereq", 32'(INTin), 32'd1);
        do_ack();
        irq[1] = 1'b0;
        tick(2);
        do_eoi();
        tick(3);
        chk("lvl_dropped", 32'(INTin), 32'd0);
        rd_chk("lvl_inserv0", 2'd3, 32'h00);

        // Nesting: channel 4 in service, then channel 1 rises
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'hFF);
        irq[4] = 1'b1;
        tick();
        irq = '0;
        tick();
        chk("nest_ch4", INTnum, 32'(VB + 4));
        do_ack();
        rd_chk("nest_ins4", 2'd3, 32'h10);
        irq[1] = 1'b1;
        tick();
        irq = '0;
        tick();
`ifdef INTC_NEST_EN
        chk("nest_pre_in", 32'(INTin), 32'd1);
        chk("nest_pre_num", INTnum, 32'(VB + 1));
        do_ack();
        rd_chk("nest_ins12", 2'd3, 32'h12);
        do_eoi();
        rd_chk("nest_eoi1", 2'd3, 32'h10);
        do_eoi();
        rd_chk("nest_eoi2", 2'd3, 32'h00);
`else
        chk("nest_wait", 32'(INTin), 32'd0);
        tick(3);
        chk("nest_wait2", 32'(INTin), 32'd0);
        do_eoi();
        rd_chk("nest_eoi", 2'd3, 32'h00);
        chk("nest_eoi_e1", 32'(INTin), 32'd0);
        tick();
        chk("nest_after_in", 32'(INTin), 32'd1);
        chk("nest_after_num", INTnum, 32'(VB + 1));
        do_ack();
        do_eoi();
`endif
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) irq[i] = ~irq[i];
            end
            int_ack   = ($urandom_range(2) == 0);
            int_eoi   = ($urandom_range(11) == 0);
            cfg_we    = ($urandom_range(9) == 0);
            cfg_addr  = 2'($urandom_range(3));
            cfg_wdata = $urandom;
            tick();
        end
        irq = '0; int_ack = 1'b0; int_eoi = 1'b0; cfg_we = 1'b0;

        // Reset in the middle of a request
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        tick();
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h01);
        irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        tick();
        chk("mid_pre_intin", 32'(INTin), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_intin", 32'(INTin), 32'd0);
        chk("mid_rst_intnum", INTnum, 32'd0);
        rd_chk("mid_rst_mask", 2'd0, 32'h0);
        rd_chk("mid_rst_mode", 2'd1, 32'h0);
        rd_chk("mid_rst_inserv", 2'd3, 32'h0);
        #3 rst = 1'b1;
        irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        tick(4);
        chk("mid_post_nomask", 32'(INTin), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
